// File: rtl/mode_counter_pkg.sv
// mode_counter_pkg
//   Shared definitions for the mode_counter block: end-of-count mode encoding.
package mode_counter_pkg;

  // End-of-count behaviour. The reserved encoding behaves as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

endpackage

// File: rtl/mode_counter_tick_gen.sv
// tick_gen
//   Prescaler for mode_counter. Produces a one-cycle tick every
//   i_prescale+1 enabled cycles.
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     asynchronous, active-high reset
//   i_en        enable; prescaler holds while low
//   i_clear     synchronous clear of the prescaler (driven by load)
//   i_prescale  interval minus one
//   o_tick      combinational tick, valid in the cycle it qualifies
module tick_gen
  import mode_counter_pkg::*;
#(
  parameter int PRESCALE_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_clear,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic                  w_tick;

  // Equality compare only: if prescale drops below the running count, the
  // counter runs on and wraps before the next tick rather than firing early.
  assign w_tick = i_en && (r_pre_cnt == i_prescale);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pre_cnt <= '0;
    end else if (i_clear) begin
      r_pre_cnt <= '0;
    end else if (i_en) begin
      if (w_tick) r_pre_cnt <= '0;
      else        r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/mode_counter.sv
// mode_counter
//   Parametrised up/down counter with runtime modulus, prescaler,
//   synchronous load and wrap / saturate / one-shot end-of-count modes.
// Ports:
//   i_clk, i_reset       clock (rising) and async active-high reset
//   i_en                 count enable, gates the prescaler
//   i_up                 1 = increment, 0 = decrement
//   i_load, i_load_val   synchronous load strobe and value
//   i_max_val            modulus top, count range 0..max_val
//   i_mode               00 wrap, 01 saturate, 10 one-shot, 11 as wrap
//   i_prescale           tick every prescale+1 enabled cycles
//   o_count              registered count
//   o_tc                 one-cycle pulse when count moves onto the terminal value
//   o_done               sticky one-shot completion flag
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_load_val,
  input  logic [WIDTH-1:0]      i_max_val,
  input  logic [1:0]            i_mode,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_tc,
  output logic                  o_done
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;

  mode_e            w_mode;
  logic             w_tick;
  logic             w_oneshot;
  logic             w_advance;
  logic             w_hit;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_target;

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_clear    (i_load),
    .i_prescale (i_prescale),
    .o_tick     (w_tick)
  );

  assign w_mode    = mode_e'(i_mode);
  assign w_oneshot = (w_mode == MODE_ONESHOT);
  assign w_target  = i_up ? i_max_val : '0;

  // Ticks while a one-shot is done are swallowed here; the prescaler still runs.
  assign w_advance = w_tick && !(w_oneshot && r_done);

  // ">=" rather than "==" so a loaded value above max_val is pulled back in
  // range by the next up-tick instead of incrementing further.
  always_comb begin
    w_next = r_count;
    if (i_up) begin
      if (r_count < i_max_val)
        w_next = r_count + WIDTH'(1);
      else if (w_mode == MODE_SAT || w_mode == MODE_ONESHOT)
        w_next = i_max_val;
      else
        w_next = '0;
    end else begin
      if (r_count != '0)
        w_next = r_count - WIDTH'(1);
      else if (w_mode == MODE_WRAP || w_mode == MODE_RSVD)
        w_next = i_max_val;
      else
        w_next = '0;
    end
  end

  // Terminal events require an actual change, so holding at the limit is silent.
  assign w_hit = (w_next != r_count) && (w_next == w_target);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_advance) begin
      r_count <= w_next;
      r_tc    <= w_hit;
      if (w_oneshot && w_hit) r_done <= 1'b1;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_done  = r_done;

endmodule

// File: tb/tb_mode_counter.sv
module tb_mode_counter;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  en;
  logic                  up;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      max_val;
  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  done;

  int n_checks = 0;
  int n_fail   = 0;

  mode_counter #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_en       (en),
    .i_up       (up),
    .i_load     (load),
    .i_load_val (load_val),
    .i_max_val  (max_val),
    .i_mode     (mode),
    .i_prescale (prescale),
    .o_count    (count),
    .o_tc       (tc),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then return to the falling edge where inputs change
  // and outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load_val = v;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    max_val  = 8'd255;
    mode     = 2'b00;
    prescale = '0;
    step();
    n_checks++;
    if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d tc=%0b done=%0b, want 0/0/0", count, tc, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 37; i++) step();
    n_checks++;
    if (count !== 8'd37) begin
      n_fail++;
      $display("FAIL run_to_37: count=%0d, want 37", count);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d tc=%0b done=%0b, want 0/0/0", count, tc, done);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_checks++;
    if (count !== 8'd1) begin
      n_fail++;
      $display("FAIL after_reset: count=%0d, want 1", count);
    end
  endtask

  task automatic test_wrap();
    int tc_seen;
    max_val = 8'd9;
    do_load(8'd0);
    n_checks++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_load: count=%0d, want 0", count);
    end
    tc_seen = 0;
    for (int i = 1; i <= 22; i++) begin
      step();
      if (tc === 1'b1) tc_seen++;
      n_checks++;
      if (count !== 8'(i % 10) || tc !== ((i % 10) == 9)) begin
        n_fail++;
        $display("FAIL wrap_step%0d: count=%0d tc=%0b, want %0d/%0b",
                 i, count, tc, i % 10, (i % 10) == 9);
      end
    end
    n_checks++;
    if (tc_seen != 2) begin
      n_fail++;
      $display("FAIL wrap_tc_laps: tc pulses=%0d, want 2", tc_seen);
    end
  endtask

  task automatic test_prescaler();
    int e;
    max_val  = 8'd255;
    prescale = 4'd2;
    do_load(8'd0);
    e = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      e++;
      n_checks++;
      if (count !== 8'(e / 3)) begin
        n_fail++;
        $display("FAIL presc_en%0d: count=%0d, want %0d", e, count, e / 3);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (count !== 8'd1) begin
        n_fail++;
        $display("FAIL presc_hold%0d: count=%0d, want 1", i, count);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      e++;
      n_checks++;
      if (count !== 8'(e / 3)) begin
        n_fail++;
        $display("FAIL presc_resume%0d: count=%0d, want %0d", e, count, e / 3);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_dn [5] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic       tc_dn  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_up [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5};
    logic       tc_up  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    prescale = '0;
    mode     = 2'b01;
    up       = 1'b0;
    max_val  = 8'd5;
    do_load(8'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (count !== exp_dn[i] || tc !== tc_dn[i]) begin
        n_fail++;
        $display("FAIL sat_down%0d: count=%0d tc=%0b, want %0d/%0b", i, count, tc, exp_dn[i], tc_dn[i]);
      end
    end
    up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if (count !== exp_up[i] || tc !== tc_up[i]) begin
        n_fail++;
        $display("FAIL sat_up%0d: count=%0d tc=%0b, want %0d/%0b", i, count, tc, exp_up[i], tc_up[i]);
      end
    end
  endtask

  task automatic test_oneshot();
    mode    = 2'b10;
    up      = 1'b1;
    max_val = 8'd4;
    do_load(8'd0);
    for (int i = 1; i <= 6; i++) begin
      step();
      n_checks++;
      if (count !== 8'((i < 4) ? i : 4) || tc !== (i == 4) || done !== (i >= 4)) begin
        n_fail++;
        $display("FAIL oneshot%0d: count=%0d tc=%0b done=%0b, want %0d/%0b/%0b",
                 i, count, tc, done, (i < 4) ? i : 4, i == 4, i >= 4);
      end
    end
    do_load(8'd1);
    n_checks++;
    if (count !== 8'd1 || done !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_reload: count=%0d done=%0b tc=%0b, want 1/0/0", count, done, tc);
    end
    for (int i = 2; i <= 4; i++) begin
      step();
      n_checks++;
      if (count !== 8'(i) || done !== (i == 4) || tc !== (i == 4)) begin
        n_fail++;
        $display("FAIL oneshot_again%0d: count=%0d tc=%0b done=%0b, want %0d/%0b/%0b",
                 i, count, tc, done, i, i == 4, i == 4);
      end
    end
  endtask

  task automatic test_load_vs_tick();
    mode    = 2'b00;
    up      = 1'b1;
    max_val = 8'd9;
    do_load(8'd2);
    do_load(8'd7);
    n_checks++;
    if (count !== 8'd7 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wins: count=%0d tc=%0b, want 7/0", count, tc);
    end
    step();
    n_checks++;
    if (count !== 8'd8) begin
      n_fail++;
      $display("FAIL after_load: count=%0d, want 8", count);
    end
  endtask

  task automatic test_out_of_range();
    mode = 2'b00;
    do_load(8'd200);
    step();
    n_checks++;
    if (count !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_wrap: count=%0d tc=%0b, want 0/0", count, tc);
    end
    mode = 2'b01;
    do_load(8'd200);
    step();
    n_checks++;
    if (count !== 8'd9 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_sat: count=%0d tc=%0b, want 9/1", count, tc);
    end
    max_val = 8'd0;
    mode    = 2'b00;
    do_load(8'd0);
    step();
    n_checks++;
    if (count !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL max0_wrap: count=%0d tc=%0b, want 0/0", count, tc);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_prescaler();
    test_saturate();
    test_oneshot();
    test_load_vs_tick();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
Parametrised, general-purpose up/down counter; next generation of the team's fixed 8-bit free-running counter. Adds runtime modulus, prescaler, direction, synchronous load and three end-of-count modes (wrap, saturate, one-shot), plus terminal-count and done flags. Used as a timebase, event counter or timeout generator by surrounding control logic.

Parameters:
WIDTH, 8, bit width of count, load_val and max_val
PRESCALE_W, 4, bit width of the prescale input

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; gates the prescaler
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_val  input  WIDTH  value written to count on load
max_val  input  WIDTH  modulus top; legal range is 0..max_val
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles
count  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered, one cycle
done  output  1  one-shot complete, registered, sticky

Behaviour:
- Reset (async, active-high): count=0, tc=0, done=0, prescaler pre_cnt=0. Takes effect immediately, independent of clk, including mid-count. First update after deassert occurs on the first rising edge with reset low.
- Prescaler: tick = en && (pre_cnt == prescale). On each edge with en=1: if tick, pre_cnt<=0; else pre_cnt<=pre_cnt+1. With en=0, pre_cnt holds. prescale=0 gives a tick every enabled cycle. If prescale is lowered below pre_cnt, tick fires when pre_cnt wraps naturally; there is no early tick.
- Terminal value T: up=1 gives T=max_val; up=0 gives T=0.
- On a tick edge, the next count is:
  - Up, count<max_val: count+1.
  - Up, count>=max_val: wrap gives 0; saturate gives max_val; one-shot gives max_val.
  - Down, count>0: count-1.
  - Down, count==0: wrap gives max_val; saturate holds 0; one-shot holds 0.
- All arithmetic is mod 2^WIDTH. Up counting never exceeds max_val via increment.
- Counting is blocked in one-shot mode while done=1. Ticks are still consumed by the prescaler.
- tc: registered. tc=1 for exactly the one cycle following a tick edge where count changed and the new value equals T. Otherwise tc=0. A tick that leaves count unchanged (saturated, max_val=0 with wrap, done) gives no tc.
- done: set on the edge where one-shot mode moves count onto T. Cleared only by load or reset. Mode changes do not clear done. done has no effect outside one-shot mode.
- load: highest priority after reset, and independent of en. On the load edge: count<=load_val, pre_cnt<=0, done<=0, tc<=0. A simultaneous tick is discarded.
- load_val>max_val is allowed. The next up-tick applies the count>=max_val rule; down counting decrements normally.
- up, mode, max_val and prescale changes are sampled every cycle. They take effect at the next tick, and count is not altered by the change itself.
- Latency: count reflects a tick or load one edge after the qualifying cycle. tc and done appear together with the new count.

Decomposition:
- Shared package mode_counter_pkg:
  - Mode enum MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10.
  - Reserved value 2'b11.
- One sub-module, tick_gen:
  - Prescaler counter with inputs clk, reset, en, clear (driven by load) and prescale.
  - Output tick.
- Top level holds the count/next-count logic, tc and done.

Test Plan:
1. Reset mid-operation: WIDTH=8, wrap, up, max_val=255, prescale=0; run to count=37, then assert reset between edges -> count=0, tc=0, done=0 before the next edge. Count is 1 one edge after reset deassert.
2. Wrap up: max_val=9, prescale=0, en=1 -> count 0,1,…,9,0,1; tc=1 only in the cycle count==9, once per lap.
3. Prescaler and enable: prescale=2 -> count steps every 3rd enabled cycle. Drop en for 5 cycles mid-interval -> count and pre_cnt hold; the interval resumes where it left off.
4. Saturate down: load_val=3, up=0 -> count 3,2,1,0,0,0; tc pulses once on reaching 0. Switch up=1 with max_val=5 -> count climbs to 5 and holds; one tc.
5. One-shot: max_val=4, up -> count 0..4, then tc and done=1; further ticks hold 4 with no tc. load with load_val=1 -> done=0 and counting resumes 2,3,4; done is set again.
6. Simultaneous and out-of-range cases:
   - load=1 with a tick in the same cycle -> count=load_val and the tick is discarded.
   - load_val=200 with max_val=9, up, wrap -> next tick gives count=0 with no tc; same in saturate -> count=9 with tc=1.
